// File: rtl/gf128_clmul_seq_if.sv
// gf128_clmul_seq_if: operand and product handshake bundle for the carry-less multiplier
interface gf128_clmul_seq_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic out_valid;
  logic out_ready;
  logic [255:0] p;
  logic busy;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/gf128_clmul_seq.sv
// gf128_clmul_seq: digit-serial MSB-first carry-less 128x128 multiplier producing the unreduced 256-bit product
module gf128_clmul_seq #(
  parameter int DIGIT_W = 8
) (
  input logic clk,
  input logic rst,
  gf128_clmul_seq_if.slave bus
);
  localparam int N = 128 / DIGIT_W;
  localparam int CW = $clog2(N);
  if (DIGIT_W < 1 || DIGIT_W > 32 || (DIGIT_W & (DIGIT_W - 1)) != 0) begin : g_bad_digit
    $error("gf128_clmul_seq: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q;
  logic in_ready_q, out_valid_q, busy_q;
  logic [127:0] a_q, b_q;
  logic [255:0] acc_q, acc_d, pp;
  logic [CW-1:0] cnt_q;
  // b_q shifts left each step so the current digit always sits in its top DIGIT_W bits
  always_comb begin
    pp = '0;
    for (int j = 0; j < DIGIT_W; j++) pp ^= b_q[128-DIGIT_W+j] ? {128'b0, a_q} << j : 256'b0;
    acc_d = (acc_q << DIGIT_W) ^ pp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.a;
          b_q <= bus.b;
          acc_q <= '0;
          cnt_q <= '0;
          in_ready_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: begin
          acc_q <= acc_d;
          b_q <= b_q << DIGIT_W;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          busy_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.p = acc_q;
endmodule

// File: tb/tb_gf128_clmul_seq.sv
// tb_gf128_clmul_seq: directed and randomized checks of the carry-less multiplier at DIGIT_W 8, 1 and 32
module tb_gf128_clmul_seq;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic dir_mode = 1;
  logic rand_go = 0;
  logic d_iv = 0;
  logic d_ordy = 0;
  logic [127:0] d_a = '0;
  logic [127:0] d_b = '0;
  logic ov[3], ir[3], bz[3], fin[3];
  logic [255:0] pv[3];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] clmul(input logic [127:0] x, input logic [127:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) if (y[i]) r ^= {128'b0, x} << i;
    return r;
  endfunction

  function automatic logic [127:0] reduce(input logic [255:0] x);
    logic [255:0] poly;
    poly = (256'h1 << 128) | 256'h87;
    for (int i = 255; i >= 128; i--) if (x[i]) x ^= poly << (i - 128);
    return x[127:0];
  endfunction

  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = x;
    for (int i = 0; i < 128; i++) begin
      if (y[i]) z ^= v;
      v = v[127] ? (v << 1) ^ 128'h87 : v << 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int DW = k == 0 ? 8 : (k == 1 ? 1 : 32);
    localparam int N = 128 / DW;
    localparam int M = k == 1 ? 150 : 1000;
    localparam int LIM = M * (N + 2) * 4 + 100;
    gf128_clmul_seq_if bus();
    gf128_clmul_seq #(.DIGIT_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    logic r_iv = 0;
    logic r_ordy = 0;
    logic [127:0] r_a = '0;
    logic [127:0] r_b = '0;
    logic live = 0;
    logic done_flag = 0;
    int age = 0;
    int nacc = 0;
    assign bus.in_valid = (k == 0 && dir_mode) ? d_iv : r_iv;
    assign bus.a = (k == 0 && dir_mode) ? d_a : r_a;
    assign bus.b = (k == 0 && dir_mode) ? d_b : r_b;
    assign bus.out_ready = (k == 0 && dir_mode) ? d_ordy : r_ordy;
    assign ov[k] = bus.out_valid;
    assign ir[k] = bus.in_ready;
    assign bz[k] = bus.busy;
    assign pv[k] = bus.p;
    assign fin[k] = done_flag;

    // reference: an operation is in flight from accept to consume; the product appears N cycles after accept
    initial begin
      logic armed;
      logic [255:0] exp_p;
      logic [127:0] ea, eb;
      armed = 0;
      exp_p = '0;
      ea = '0;
      eb = '0;
      forever begin
        @(negedge clk);
        if (armed) begin
          chk($sformatf("dw%0d in_ready", DW), 256'(bus.in_ready), 256'(!live));
          chk($sformatf("dw%0d busy", DW), 256'(bus.busy), 256'(live));
          chk($sformatf("dw%0d out_valid", DW), 256'(bus.out_valid), 256'(live && age > N));
          if (live && age > N) begin
            chk($sformatf("dw%0d p", DW), bus.p, exp_p);
            chk($sformatf("dw%0d p255", DW), 256'(bus.p[255]), 256'(0));
          end
        end
        if (rst) begin
          armed = 1;
          live = 0;
        end else if (live) begin
          if (age > N && bus.out_ready) begin
            live = 0;
            chk($sformatf("dw%0d reduced", DW), 256'(reduce(bus.p)), 256'(gfmul(ea, eb)));
          end else age++;
        end else if (bus.in_valid) begin
          live = 1;
          age = 1;
          ea = bus.a;
          eb = bus.b;
          exp_p = clmul(bus.a, bus.b);
          nacc++;
        end
      end
    end

    initial begin
      int budget;
      budget = 0;
      wait (rand_go);
      while ((nacc < M || live) && budget < LIM) begin
        @(posedge clk);
        #1;
        budget++;
        r_iv = nacc < M && $urandom_range(0, 3) != 0;
        r_a = rnd128();
        r_b = rnd128();
        r_ordy = $urandom_range(0, 3) != 0;
      end
      r_iv = 0;
      chk($sformatf("dw%0d random within budget", DW), 256'(budget < LIM), 256'(1));
      done_flag = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [127:0] a, input logic [127:0] b, output int lat, output logic [255:0] p);
    for (int i = 0; i < 400 && !ir[0]; i++) step();
    d_a = a;
    d_b = b;
    d_iv = 1;
    step();
    d_iv = 0;
    d_a = rnd128();
    d_b = rnd128();
    lat = 0;
    while (!ov[0] && lat < 400) begin
      step();
      lat++;
    end
    p = pv[0];
  endtask

  task automatic consume();
    d_ordy = 1;
    step();
    d_ordy = 0;
    chk("in_ready after consume", 256'(ir[0]), 256'(1));
    chk("out_valid after consume", 256'(ov[0]), 256'(0));
  endtask

  initial begin
    int lat, seen;
    logic [255:0] p, p0;
    chk("model clmul 87x3", clmul(128'h87, 128'h3), 256'h189);
    chk("model clmul top", clmul(128'h1 << 127, 128'h1 << 127), 256'h1 << 254);
    chk("model gfmul wrap", 256'(gfmul(128'h1 << 127, 128'h2)), 256'h87);
    chk("model reduce x128", 256'(reduce(256'h1 << 128)), 256'h87);
    repeat (3) step();
    rst = 0;
    step();
    chk("reset in_ready", 256'(ir[0]), 256'(1));
    chk("reset out_valid", 256'(ov[0]), 256'(0));
    chk("reset busy", 256'(bz[0]), 256'(0));
    chk("reset p", pv[0], 256'h0);

    run_op(128'h1, 128'h1, lat, p);
    chk("latency 1x1", 256'(lat), 256'(16));
    chk("p 1x1", p, 256'h1);
    consume();
    run_op(128'h87, 128'h3, lat, p);
    chk("p 87x3", p, 256'h189);
    consume();
    run_op(~128'h0, 128'h1, lat, p);
    chk("p ones x1", p, {128'h0, ~128'h0});
    consume();
    run_op(128'h1 << 127, 128'h1 << 127, lat, p);
    chk("p x127 sq", p, 256'h1 << 254);
    consume();

    run_op(rnd128(), rnd128(), lat, p0);
    for (int i = 0; i < 5; i++) begin
      d_iv = i[0];
      d_a = rnd128();
      d_b = rnd128();
      step();
      chk("backpressure p", pv[0], p0);
      chk("backpressure in_ready", 256'(ir[0]), 256'(0));
      chk("backpressure out_valid", 256'(ov[0]), 256'(1));
      chk("backpressure busy", 256'(bz[0]), 256'(1));
    end
    d_iv = 0;
    consume();
    run_op(128'h3, 128'h5, lat, p);
    chk("p 3x5", p, 256'hf);
    consume();

    d_a = rnd128();
    d_b = rnd128();
    d_iv = 1;
    step();
    d_iv = 0;
    repeat (6) step();
    rst = 1;
    step();
    rst = 0;
    chk("midbusy reset in_ready", 256'(ir[0]), 256'(1));
    chk("midbusy reset out_valid", 256'(ov[0]), 256'(0));
    chk("midbusy reset busy", 256'(bz[0]), 256'(0));
    chk("midbusy reset p", pv[0], 256'h0);
    seen = 0;
    d_ordy = 1;
    repeat (30) begin
      step();
      if (ov[0]) seen++;
    end
    d_ordy = 0;
    chk("no stale out_valid", 256'(seen), 256'(0));

    rst = 1;
    d_iv = 1;
    d_a = rnd128();
    step();
    rst = 0;
    d_iv = 0;
    chk("reset beats in_valid ready", 256'(ir[0]), 256'(1));
    chk("reset beats in_valid busy", 256'(bz[0]), 256'(0));
    run_op(128'h87, 128'h87, lat, p);
    chk("p after reset 87sq", p, 256'h4015);
    consume();

    dir_mode = 0;
    rand_go = 1;
    wait (fin[0] && fin[1] && fin[2]);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
